// File: rtl/btb_2way_sat_if.sv
// Lookup / update / flush bundle between the fetch and execute stages and the BTB.
interface btb_2way_sat_if #(parameter int PC_WIDTH = 32);
  logic                lk_hit;
  logic                lk_taken;
  logic [PC_WIDTH-1:0] lk_pc;
  logic [PC_WIDTH-1:0] lk_target;
  logic                upd_en;
  logic                upd_taken;
  logic [PC_WIDTH-1:0] upd_pc;
  logic [PC_WIDTH-1:0] upd_target;
  logic                flush;

  modport master (output lk_pc, upd_en, upd_pc, upd_taken, upd_target, flush,
                  input  lk_hit, lk_taken, lk_target);
  modport slave  (input  lk_pc, upd_en, upd_pc, upd_taken, upd_target, flush,
                  output lk_hit, lk_taken, lk_target);
endinterface

// File: rtl/btb_2way_sat.sv
// 2-way set-associative BTB with 2-bit saturating direction counters and per-set LRU.
// Lookup is combinational on pre-edge state; one resolved-branch update per cycle.
module btb_2way_sat #(
  parameter int PC_WIDTH = 32,
  parameter int IDX_W    = 4
) (
  input logic           clk,
  input logic           rst_n,
  btb_2way_sat_if.slave bus
);
  localparam int SETS  = 1 << IDX_W;
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  logic                vld_q [2][SETS];
  logic [TAG_W-1:0]    tag_q [2][SETS];
  logic [PC_WIDTH-1:0] tgt_q [2][SETS];
  logic [1:0]          ctr_q [2][SETS];
  logic [SETS-1:0]     lru_q;   // way to evict next in each set

  logic [IDX_W-1:0] lk_idx, u_idx;
  logic [TAG_W-1:0] lk_tag, u_tag;
  logic [1:0]       lk_hw, u_hw;
  logic             u_hit, u_way, a_way;
  logic [1:0]       u_ctr, u_ctr_nxt;
  logic             unused_ok;

  assign lk_idx    = bus.lk_pc[IDX_W+1:2];
  assign lk_tag    = bus.lk_pc[PC_WIDTH-1:IDX_W+2];
  assign u_idx     = bus.upd_pc[IDX_W+1:2];
  assign u_tag     = bus.upd_pc[PC_WIDTH-1:IDX_W+2];
  assign unused_ok = ^{bus.lk_pc[1:0], bus.upd_pc[1:0]};

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign lk_hw[w] = vld_q[w][lk_idx] && (tag_q[w][lk_idx] == lk_tag);
    assign u_hw[w]  = vld_q[w][u_idx]  && (tag_q[w][u_idx]  == u_tag);
  end

  // Lookup: way0 takes priority should both ways ever match
  always_comb begin
    bus.lk_hit    = 1'b0;
    bus.lk_taken  = 1'b0;
    bus.lk_target = '0;
    if (lk_hw[0]) begin
      bus.lk_hit    = 1'b1;
      bus.lk_taken  = ctr_q[0][lk_idx][1];
      bus.lk_target = tgt_q[0][lk_idx];
    end else if (lk_hw[1]) begin
      bus.lk_hit    = 1'b1;
      bus.lk_taken  = ctr_q[1][lk_idx][1];
      bus.lk_target = tgt_q[1][lk_idx];
    end
  end

  // Update side: hit way, saturating counter step, allocation victim
  always_comb begin
    u_hit     = |u_hw;
    u_way     = ~u_hw[0];
    u_ctr     = ctr_q[u_way][u_idx];
    u_ctr_nxt = u_ctr;
    if (bus.upd_taken) begin
      if (u_ctr != 2'b11) u_ctr_nxt = u_ctr + 2'd1;
    end else begin
      if (u_ctr != 2'b00) u_ctr_nxt = u_ctr - 2'd1;
    end
    if (!vld_q[0][u_idx])      a_way = 1'b0;
    else if (!vld_q[1][u_idx]) a_way = 1'b1;
    else                       a_way = lru_q[u_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < SETS; s++) begin
          vld_q[w][s] <= 1'b0;
          tag_q[w][s] <= '0;
          tgt_q[w][s] <= '0;
          ctr_q[w][s] <= 2'b01;
        end
      lru_q <= '0;
    end else if (bus.flush) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < SETS; s++) begin
          vld_q[w][s] <= 1'b0;
          tag_q[w][s] <= '0;
          tgt_q[w][s] <= '0;
          ctr_q[w][s] <= 2'b01;
        end
      lru_q <= '0;
    end else if (bus.upd_en) begin
      if (u_hit) begin
        ctr_q[u_way][u_idx] <= u_ctr_nxt;
        if (bus.upd_taken) tgt_q[u_way][u_idx] <= bus.upd_target;
        lru_q[u_idx] <= ~u_way;
      end else if (bus.upd_taken) begin
        vld_q[a_way][u_idx] <= 1'b1;
        tag_q[a_way][u_idx] <= u_tag;
        tgt_q[a_way][u_idx] <= bus.upd_target;
        ctr_q[a_way][u_idx] <= 2'b10;
        lru_q[u_idx]        <= ~a_way;
      end
    end
  end
endmodule
